pipe_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. Collects stall and redirect requests from IF, ID, EX and MEM, and drives the shared `stall_command` and `jp` buses that every pipeline register (IF_ID, ID_EX, ...) samples. It sequences multi-cycle load-use bubbles, holds ID-stage redirects that arrive while the front end is frozen, and cancels younger requests when EX redirects.

---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, deferred ID jumps, EX cancel.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
package pipe_ctrl_pkg;
  localparam int StallLevelLen = 2;
  localparam int JumpInfoLen   = 2;
  localparam logic [StallLevelLen-1:0] Stall_Null   = 2'd0;
  localparam logic [StallLevelLen-1:0] Stall_Decode = 2'd1;
  localparam logic [StallLevelLen-1:0] Stall_Issue  = 2'd2;
  localparam logic [StallLevelLen-1:0] Stall_All    = 2'd3;
  localparam int Jump_ID = 0;
  localparam int Jump_EX = 1;
endpackage

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_stall_req,
  input  logic                     id_lu_req,
  input  logic                     id_jump_req,
  input  logic                     ex_jump_req,
  input  logic                     mem_stall_req,
  output logic [StallLevelLen-1:0] stall_command,
  output logic [JumpInfoLen-1:0]   jp,
  output logic [31:0]              stall_cycles,
  output logic [15:0]              flush_count
);

  typedef enum logic [1:0] {
    RUN,
    LU_HOLD,
    MEM_WAIT
  } state_e;

  localparam logic [2:0] LuLoad = 3'(LU_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic       pend_id_q, pend_id_d;
  logic       lu_busy;
  logic       front_held;
  logic       id_want;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      lu_cnt_q  <= 3'd0;
      pend_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lu_cnt_q  <= lu_cnt_d;
      pend_id_q <= pend_id_d;
    end
  end

  // MEM_WAIT with a live count is a suspended bubble; it resumes the
  // same cycle mem_stall_req drops so no extra dead cycle appears.
  always_comb begin
    lu_busy = (state_q == LU_HOLD) ||
              (state_q == MEM_WAIT && lu_cnt_q != 3'd0);
    id_want = id_jump_req | pend_id_q;

    stall_command = Stall_Null;
    if (rst)
      stall_command = Stall_Null;
    else if (mem_stall_req)
      stall_command = Stall_All;
    else if (lu_busy || id_lu_req)
      stall_command = Stall_Issue;
    else if (if_stall_req)
      stall_command = Stall_Decode;

    front_held = (stall_command == Stall_All) ||
                 (stall_command == Stall_Issue);

    jp = '0;
    jp[Jump_EX] = ex_jump_req & ~rst;
    jp[Jump_ID] = id_want & ~ex_jump_req & ~front_held & ~rst;
  end

  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    pend_id_d = 1'b0;

    if (!ex_jump_req && front_held && id_want)
      pend_id_d = 1'b1;

    if (mem_stall_req) begin
      state_d = MEM_WAIT;
      if (ex_jump_req)
        lu_cnt_d = 3'd0;
    end else if (ex_jump_req) begin
      state_d  = RUN;
      lu_cnt_d = 3'd0;
    end else if (id_lu_req) begin
      lu_cnt_d = LuLoad;
      state_d  = (LuLoad != 3'd0) ? LU_HOLD : RUN;
    end else if (lu_busy) begin
      if (lu_cnt_q <= 3'd1) begin
        state_d  = RUN;
        lu_cnt_d = 3'd0;
      end else begin
        state_d  = LU_HOLD;
        lu_cnt_d = lu_cnt_q - 3'd1;
      end
    end else begin
      state_d = RUN;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_command != Stall_Null && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (jp[Jump_EX] && flush_count_q != '1)
      flush_count_d = flush_count_q + 16'd1;
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
